gl_wb_arbiter: RTL and testbench

Writeback arbiter in front of the graduation list's scalar writeback ports. Functional units (ALU, MUL, DIV, MEM, FPU, …) raise completion requests carrying a GL index and a `gl_instruction_t` payload. Each cycle the block grants up to `NUM_PORTS` of them with rotating (round-robin) priority and registers the winners onto the GL's `instruction_writeback_*` inputs. It sits between the execution-stage result buses and the graduation list in the writeback stage.

---
 rtl/gl_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_gl_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gl_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to NUM_PORTS completion requests per cycle onto the GL writeback ports.
// Optional starvation aging is enabled by defining GL_WB_ARB_AGING_EN.

package gl_wb_arbiter_pkg;
    localparam int NUM_SCALAR_WB = 2;
    localparam int GL_INDEX_W    = 5;

    typedef logic [GL_INDEX_W-1:0] gl_index_t;

    typedef struct packed {
        logic [11:0] csr_addr;
        logic        exception;
        logic [63:0] result;
    } gl_instruction_t;
endpackage

module gl_wb_arbiter
    import gl_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 5,
    parameter int NUM_PORTS = NUM_SCALAR_WB,
    parameter int AGE_MAX   = 7
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  gl_index_t       [NUM_REQ-1:0]   req_gl_index_i,
    input  gl_instruction_t [NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic                            flush_commit_i,
    output logic [NUM_PORTS-1:0]            wb_enable_o,
    output gl_index_t       [NUM_PORTS-1:0] wb_index_o,
    output gl_instruction_t [NUM_PORTS-1:0] wb_data_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [NUM_REQ-1:0]               grant_s;
    logic [NUM_PORTS-1:0]             port_vld_s;
    logic [NUM_PORTS-1:0][PTR_W-1:0]  port_sel_s;
    logic                             aged_vld_s;
    logic [PTR_W-1:0]                 aged_idx_s;
    logic [NUM_PORTS-1:0]             wb_enable_q, wb_enable_d;
    gl_index_t       [NUM_PORTS-1:0]  wb_index_q, wb_index_d;
    gl_instruction_t [NUM_PORTS-1:0]  wb_data_q, wb_data_d;

`ifdef GL_WB_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [NUM_REQ-1:0][AGE_W-1:0] age_q, age_d;

    // Starved requester search: descending scan so the lowest saturated index wins.
    always_comb begin
        aged_vld_s = 1'b0;
        aged_idx_s = '0;
        for (int r = NUM_REQ - 1; r >= 0; r--) begin
            if (req_valid_i[r] && (age_q[r] == AGE_W'(AGE_MAX))) begin
                aged_vld_s = 1'b1;
                aged_idx_s = PTR_W'(r);
            end
        end
    end

    // Saturating wait counters, cleared on grant, idle or flush.
    always_comb begin
        age_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (flush_commit_i || !req_valid_i[r] || grant_s[r]) begin
                age_d[r] = '0;
            end else if (age_q[r] == AGE_W'(AGE_MAX)) begin
                age_d[r] = age_q[r];
            end else begin
                age_d[r] = age_q[r] + AGE_W'(1);
            end
        end
    end

    // Age counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign aged_vld_s = 1'b0;
    assign aged_idx_s = '0;
`endif

    // Grant selection: aged winner takes port 0, the rest follow the rotating scan from ptr.
    always_comb begin
        int cnt;
        int idx;
        grant_s    = '0;
        port_vld_s = '0;
        port_sel_s = '0;
        ptr_d      = ptr_q;
        cnt        = 0;
        idx        = 0;
        if (aged_vld_s) begin
            grant_s[aged_idx_s] = 1'b1;
            port_vld_s[0]       = 1'b1;
            port_sel_s[0]       = aged_idx_s;
            cnt                 = 1;
        end else begin
            cnt = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            for (int r = 0; r < NUM_REQ; r++) begin
                if ((r == idx) && req_valid_i[r] && !grant_s[r] && (cnt < NUM_PORTS)) begin
                    grant_s[r] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p == cnt) begin
                            port_vld_s[p] = 1'b1;
                            port_sel_s[p] = PTR_W'(r);
                        end
                    end
                    // Only rotating grants move the pointer; an aged grant leaves it alone.
                    ptr_d = PTR_W'((r + 1) % NUM_REQ);
                    cnt   = cnt + 1;
                end
            end
        end
        if (flush_commit_i) begin
            grant_s    = '0;
            port_vld_s = '0;
            ptr_d      = '0;
        end else begin
            ptr_d = ptr_d;
        end
    end

    // Next writeback register contents: payload muxed per port from its selected requester.
    always_comb begin
        wb_enable_d = port_vld_s;
        wb_index_d  = '0;
        wb_data_d   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (port_vld_s[p] && (port_sel_s[p] == PTR_W'(r))) begin
                    wb_index_d[p] = req_gl_index_i[r];
                    wb_data_d[p]  = req_data_i[r];
                end
            end
        end
    end

    // Pointer and writeback output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q       <= '0;
            wb_enable_q <= '0;
            wb_index_q  <= '0;
            wb_data_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wb_enable_q <= wb_enable_d;
            wb_index_q  <= wb_index_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign req_ready_o = grant_s;
    assign wb_enable_o = wb_enable_q;
    assign wb_index_o  = wb_index_q;
    assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_gl_wb_arbiter.sv
// Self-checking bench for gl_wb_arbiter (4 requesters, 2 ports); writeback payloads are checked through a scoreboard queue.

module tb_gl_wb_arbiter;
    import gl_wb_arbiter_pkg::*;

    localparam int NR         = 4;
    localparam int NP         = 2;
    localparam int AGE_MAX_TB = 2;

    typedef struct packed {
        gl_index_t       idx;
        gl_instruction_t data;
    } sb_entry_t;

    logic                     clk_i          = 1'b0;
    logic                     rstn_i         = 1'b1;
    logic [NR-1:0]            req_valid_i    = '0;
    logic                     flush_commit_i = 1'b0;
    gl_index_t       [NR-1:0] req_gl_index_i;
    gl_instruction_t [NR-1:0] req_data_i;
    logic [NR-1:0]            req_ready_o;
    logic [NP-1:0]            wb_enable_o;
    gl_index_t       [NP-1:0] wb_index_o;
    gl_instruction_t [NP-1:0] wb_data_o;

    gl_index_t       idx_tb [NR];
    gl_instruction_t dat_tb [NR];

    int        n_checks = 0;
    int        n_fail   = 0;
    sb_entry_t sb_q [$];

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            req_gl_index_i[r] = idx_tb[r];
            req_data_i[r]     = dat_tb[r];
        end
    end

    gl_wb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .AGE_MAX(AGE_MAX_TB)) u_dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_gl_index_i (req_gl_index_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .flush_commit_i (flush_commit_i),
        .wb_enable_o    (wb_enable_o),
        .wb_index_o     (wb_index_o),
        .wb_data_o      (wb_data_o)
    );

`ifdef GL_WB_ARB_AGING_EN
    // Single-port instance: with one port a requester can actually starve long enough to age.
    logic [NR-1:0]            a_valid = '0;
    logic                     a_flush = 1'b0;
    logic [NR-1:0]            a_ready;
    logic [0:0]               a_wb_enable;
    gl_index_t       [0:0]    a_wb_index;
    gl_instruction_t [0:0]    a_wb_data;

    gl_wb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(1), .AGE_MAX(AGE_MAX_TB)) u_age (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (a_valid),
        .req_gl_index_i (req_gl_index_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (a_ready),
        .flush_commit_i (a_flush),
        .wb_enable_o    (a_wb_enable),
        .wb_index_o     (a_wb_index),
        .wb_data_o      (a_wb_data)
    );
`endif

    function automatic gl_instruction_t mk_data(input int r, input gl_index_t idx);
        gl_instruction_t d;
        d.csr_addr  = {4'hA, 3'(r), idx};
        d.exception = idx[0];
        d.result    = {16'hDEAD, 40'h0, 3'(r), idx};
        return d;
    endfunction

    task automatic set_req(input int r, input gl_index_t idx);
        idx_tb[r] = idx;
        dat_tb[r] = mk_data(r, idx);
    endtask

    task automatic push_exp(input int r);
        sb_q.push_back(sb_entry_t'{idx: idx_tb[r], data: dat_tb[r]});
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic fl);
        @(negedge clk_i);
        req_valid_i    = v;
        flush_commit_i = fl;
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0000", req_ready_o); end
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL reset_enable: got %b, expected 00", wb_enable_o); end
        n_checks++; if (wb_index_o !== '0) begin n_fail++; $display("FAIL reset_index: got %h, expected 0", wb_index_o); end
        n_checks++; if (wb_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", wb_data_o); end
        rstn_i = 1'b1;
        drive(4'b0000, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b, expected 0000", req_ready_o); end
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL idle_enable: got %b, expected 00", wb_enable_o); end
    endtask

    task automatic test_round_robin();
        set_req(0, 5'd3); set_req(1, 5'd7); set_req(2, 5'd9); set_req(3, 5'd12);
        drive(4'b1111, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL rr_ready0: got %b, expected 0011", req_ready_o); end
        push_exp(0); push_exp(1);
        drive(4'b1100, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b11) begin n_fail++; $display("FAIL rr_enable1: got %b, expected 11", wb_enable_o); end
        n_checks++; if (wb_index_o !== {5'd7, 5'd3}) begin n_fail++; $display("FAIL rr_index1: got %h, expected {7,3}", wb_index_o); end
        n_checks++; if (req_ready_o !== 4'b1100) begin n_fail++; $display("FAIL rr_ready1: got %b, expected 1100", req_ready_o); end
        push_exp(2); push_exp(3);
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b11) begin n_fail++; $display("FAIL rr_enable2: got %b, expected 11", wb_enable_o); end
        n_checks++; if (wb_index_o !== {5'd12, 5'd9}) begin n_fail++; $display("FAIL rr_index2: got %h, expected {12,9}", wb_index_o); end
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rr_ready2: got %b, expected 0000", req_ready_o); end
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL rr_enable3: got %b, expected 00", wb_enable_o); end
    endtask

    task automatic test_wrap();
        drive(4'b0100, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b, expected 0100", req_ready_o); end
        push_exp(2);
        drive(4'b1001, 1'b0);
        n_checks++; if (req_ready_o !== 4'b1001) begin n_fail++; $display("FAIL wrap_ready: got %b, expected 1001", req_ready_o); end
        push_exp(3); push_exp(0);
        drive(4'b1111, 1'b0);
        n_checks++; if (wb_index_o !== {5'd3, 5'd12}) begin n_fail++; $display("FAIL wrap_ports: got %h, expected {3,12}", wb_index_o); end
        n_checks++; if (req_ready_o !== 4'b0110) begin n_fail++; $display("FAIL wrap_ptr: got %b, expected 0110", req_ready_o); end
        push_exp(1); push_exp(2);
    endtask

    task automatic test_flush();
        drive(4'b1111, 1'b1);
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL flush_ready: got %b, expected 0000", req_ready_o); end
        n_checks++; if (wb_enable_o !== 2'b11) begin n_fail++; $display("FAIL flush_inflight: got %b, expected 11", wb_enable_o); end
        drive(4'b1111, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL flush_enable: got %b, expected 00", wb_enable_o); end
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL flush_ptr: got %b, expected 0011", req_ready_o); end
        push_exp(0); push_exp(1);
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_index_o !== {5'd7, 5'd3}) begin n_fail++; $display("FAIL flush_regrant: got %h, expected {7,3}", wb_index_o); end
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_backpressure();
        set_req(2, 5'd21);
        drive(4'b0111, 1'b1);
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_lost1: got %b, expected 0000", req_ready_o); end
        drive(4'b0111, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL bp_lost2: got %b, expected 0011", req_ready_o); end
        push_exp(0); push_exp(1);
        drive(4'b0100, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b, expected 0100", req_ready_o); end
        push_exp(2);
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b01) begin n_fail++; $display("FAIL bp_enable: got %b, expected 01", wb_enable_o); end
        n_checks++; if (wb_index_o[0] !== 5'd21) begin n_fail++; $display("FAIL bp_index: got %0d, expected 21", wb_index_o[0]); end
        n_checks++; if (wb_data_o[0] !== mk_data(2, 5'd21)) begin n_fail++; $display("FAIL bp_data: got %h, expected %h", wb_data_o[0], mk_data(2, 5'd21)); end
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL bp_once: got %b, expected 00", wb_enable_o); end
    endtask

    task automatic test_async_reset();
        drive(4'b1001, 1'b0);
        n_checks++; if (req_ready_o !== 4'b1001) begin n_fail++; $display("FAIL arst_ready: got %b, expected 1001", req_ready_o); end
        push_exp(3); push_exp(0);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        n_checks++; if (wb_enable_o !== 2'b00) begin n_fail++; $display("FAIL arst_enable: got %b, expected 00", wb_enable_o); end
        n_checks++; if (wb_index_o !== '0 || wb_data_o !== '0) begin n_fail++; $display("FAIL arst_payload: got %h/%h, expected 0/0", wb_index_o, wb_data_o); end
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        rstn_i      = 1'b1;
        drive(4'b1011, 1'b0);
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL arst_ptr: got %b, expected 0011", req_ready_o); end
        push_exp(0); push_exp(1);
        drive(4'b0000, 1'b0);
        n_checks++; if (wb_enable_o !== 2'b11) begin n_fail++; $display("FAIL arst_resume: got %b, expected 11", wb_enable_o); end
        drive(4'b0000, 1'b0);
    endtask

`ifdef GL_WB_ARB_AGING_EN
    task automatic drive_age(input logic [NR-1:0] v);
        @(negedge clk_i);
        a_valid = v;
        #1;
    endtask

    task automatic test_aging();
        set_req(0, 5'd1); set_req(1, 5'd2); set_req(2, 5'd4); set_req(3, 5'd8);
        drive_age(4'b1011);
        n_checks++; if (a_ready !== 4'b0001) begin n_fail++; $display("FAIL age_c1: got %b, expected 0001", a_ready); end
        drive_age(4'b1010);
        n_checks++; if (a_wb_index[0] !== 5'd1) begin n_fail++; $display("FAIL age_wb1: got %0d, expected 1", a_wb_index[0]); end
        n_checks++; if (a_ready !== 4'b0010) begin n_fail++; $display("FAIL age_c2: got %b, expected 0010", a_ready); end
        drive_age(4'b1100);
        n_checks++; if (a_wb_index[0] !== 5'd2) begin n_fail++; $display("FAIL age_wb2: got %0d, expected 2", a_wb_index[0]); end
        n_checks++; if (a_ready !== 4'b1000) begin n_fail++; $display("FAIL age_aged: got %b, expected 1000", a_ready); end
        drive_age(4'b0101);
        n_checks++; if (a_wb_index[0] !== 5'd8 || a_wb_data[0] !== mk_data(3, 5'd8)) begin n_fail++; $display("FAIL age_wb3: got %0d/%h, expected 8/%h", a_wb_index[0], a_wb_data[0], mk_data(3, 5'd8)); end
        n_checks++; if (a_ready !== 4'b0100) begin n_fail++; $display("FAIL age_ptr_kept: got %b, expected 0100", a_ready); end
        drive_age(4'b0001);
        n_checks++; if (a_wb_index[0] !== 5'd4) begin n_fail++; $display("FAIL age_wb4: got %0d, expected 4", a_wb_index[0]); end
        n_checks++; if (a_ready !== 4'b0001) begin n_fail++; $display("FAIL age_c5: got %b, expected 0001", a_ready); end
        drive_age(4'b0000);
        n_checks++; if (a_wb_enable !== 1'b1 || a_wb_index[0] !== 5'd1) begin n_fail++; $display("FAIL age_wb5: got %b/%0d, expected 1/1", a_wb_enable, a_wb_index[0]); end
        drive_age(4'b0000);
        n_checks++; if (a_wb_enable !== 1'b0) begin n_fail++; $display("FAIL age_idle: got %b, expected 0", a_wb_enable); end
    endtask
`endif

    initial begin
        for (int r = 0; r < NR; r++) begin
            set_req(r, 5'd0);
        end
        // Scoreboard monitor: every enabled port must match the next expected payload in order.
        fork
            forever begin
                sb_entry_t e;
                @(posedge clk_i);
                #1;
                for (int p = 0; p < NP; p++) begin
                    n_checks++;
                    if (wb_enable_o[p]) begin
                        if (sb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_extra port%0d: got index %0d, expected no writeback", p, wb_index_o[p]);
                        end else begin
                            e = sb_q.pop_front();
                            if (wb_index_o[p] !== e.idx || wb_data_o[p] !== e.data) begin
                                n_fail++;
                                $display("FAIL sb_payload port%0d: got %0d/%h, expected %0d/%h", p, wb_index_o[p], wb_data_o[p], e.idx, e.data);
                            end
                        end
                    end else if (wb_index_o[p] !== '0 || wb_data_o[p] !== '0) begin
                        n_fail++;
                        $display("FAIL sb_idle port%0d: got %0d/%h, expected 0/0", p, wb_index_o[p], wb_data_o[p]);
                    end
                end
            end
        join_none

        test_reset();
        test_round_robin();
        test_wrap();
        test_flush();
        test_backpressure();
        test_async_reset();
`ifdef GL_WB_ARB_AGING_EN
        test_aging();
`endif
        drive(4'b0000, 1'b0);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_missing: got %0d pending writebacks, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
